sad_window_sequencer: RTL

// - Row sequencer for the sliding-window sum accumulator in the stereo SAD path.
// - Accepts a per-row pixel-cost stream (valid/ready) and drives the accumulator input.
// - The accumulator has no clear and no enable, so this block zero-flushes its delay line between rows.
// - Tags which accumulator outputs are complete windows: sum_valid, plus the window-centre column.

---
 rtl/sad_window_sequencer.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/sad_window_sequencer.sv
// sad_window_sequencer: row sequencer in front of the sliding-window sum
// accumulator of the stereo SAD path.
//
// The accumulator has no clear and no enable, so this block controls it
// entirely through acc_in:
//  - it forwards the accepted cost samples of a row,
//  - it drives zeros in every other cycle,
//  - after each row it drives WINDOW_SIZE+ACC_LAT zeros so that window_sum
//    is back at 0 before the next row can start.
// It also tags each accumulator output that covers a complete window with
// sum_valid and the window-centre column sum_col.
//
// Optional feature, selected at build time by the macro SEQ_ZERO_PAD_EN:
//  - (WINDOW_SIZE-1)/2 zero samples are inserted before and after every row,
//    so an N-sample row produces N complete windows with sum_col 0..N-1.
//  - WINDOW_SIZE must be odd in that build.
//
// Without the macro, an N-sample row produces N-WINDOW_SIZE+1 windows with
// sum_col running from P to N-1-P.

module sad_window_sequencer #(
  parameter int WINDOW_SIZE = 5,
  parameter int NUM_BITS    = 11,
  parameter int ACC_LAT     = 1,
  parameter int COL_W       = 10
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_BITS-1:0] pix_in,
  input  logic                pix_valid,
  input  logic                row_start,
  input  logic                row_end,
  output logic                pix_ready,
  output logic [NUM_BITS-1:0] acc_in,
  output logic                sum_valid,
  output logic [COL_W-1:0]    sum_col,
  output logic                busy,
  output logic                row_err
);

  localparam int P         = (WINDOW_SIZE - 1) / 2;
  localparam int FLUSH_LEN = WINDOW_SIZE + ACC_LAT;
  localparam int CNT_W     = $clog2(FLUSH_LEN + 1);

  localparam logic [COL_W-1:0] K_MAX    = '1;
  localparam logic [COL_W-1:0] LAST_TAP = COL_W'(WINDOW_SIZE - 1);

`ifdef SEQ_ZERO_PAD_EN
  // Leading pad zeros shift the sample index by P, so the window that ends
  // at padded index k is centred on real column k-2P.
  localparam logic [COL_W-1:0] COL_OFF = COL_W'(2 * P);
  localparam logic [COL_W-1:0] FIRST_K = COL_W'(P);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PAD_PRE  = 3'd1,
    STREAM   = 3'd2,
    PAD_POST = 3'd3,
    FLUSH    = 3'd4
  } state_t;
`else
  localparam logic [COL_W-1:0] COL_OFF = COL_W'(P);
  localparam logic [COL_W-1:0] FIRST_K = '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;
`endif

  state_t             state;
  logic               ready_q;
  logic [COL_W-1:0]   k_cnt;
  logic [CNT_W-1:0]   cnt;
  logic               tag_v   [0:ACC_LAT];
  logic [COL_W-1:0]   tag_col [0:ACC_LAT];
  logic               accept;

  // The sample index counter saturates instead of wrapping.
  function automatic logic [COL_W-1:0] inc_sat(input logic [COL_W-1:0] v);
    return (v == K_MAX) ? v : v + 1'b1;
  endfunction

  // A window is complete once the sample index reaches WINDOW_SIZE-1.
  function automatic logic is_full(input logic [COL_W-1:0] k);
    return (k >= LAST_TAP);
  endfunction

  function automatic logic [COL_W-1:0] centre_of(input logic [COL_W-1:0] k);
    return is_full(k) ? (k - COL_OFF) : '0;
  endfunction

`ifdef SEQ_ZERO_PAD_EN
  // A row start seen in IDLE is held upstream while the leading pad runs.
  assign pix_ready = ready_q & ~((state == IDLE) & pix_valid & row_start);
`else
  assign pix_ready = ready_q;
`endif

  assign accept    = pix_valid & pix_ready;
  assign sum_valid = tag_v[ACC_LAT];
  assign sum_col   = tag_col[ACC_LAT];

  // Row FSM: drives acc_in, handshake, error flag and the window tag pipeline.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      ready_q <= 1'b0;
      acc_in  <= '0;
      busy    <= 1'b0;
      row_err <= 1'b0;
      k_cnt   <= '0;
      cnt     <= '0;
      for (int i = 0; i <= ACC_LAT; i++) begin
        tag_v[i]   <= 1'b0;
        tag_col[i] <= '0;
      end
    end else begin
      // The tag travels alongside the sample through the accumulator latency.
      for (int i = ACC_LAT; i >= 1; i--) begin
        tag_v[i]   <= tag_v[i-1];
        tag_col[i] <= tag_col[i-1];
      end
      acc_in     <= '0;
      tag_v[0]   <= 1'b0;
      tag_col[0] <= '0;

      case (state)
        IDLE: begin
          k_cnt   <= '0;
          ready_q <= 1'b1;
          busy    <= 1'b0;
`ifdef SEQ_ZERO_PAD_EN
          if (ready_q && pix_valid && row_start) begin
            state   <= PAD_PRE;
            cnt     <= CNT_W'(P - 1);
            ready_q <= 1'b0;
            busy    <= 1'b1;
          end
`else
          if (accept && row_start) begin
            acc_in <= pix_in;
            k_cnt  <= inc_sat('0);
            busy   <= 1'b1;
            if (row_end) begin
              state   <= FLUSH;
              cnt     <= CNT_W'(FLUSH_LEN - 1);
              ready_q <= 1'b0;
            end else begin
              state <= STREAM;
            end
          end
`endif
        end

`ifdef SEQ_ZERO_PAD_EN
        PAD_PRE: begin
          tag_v[0]   <= is_full(k_cnt);
          tag_col[0] <= centre_of(k_cnt);
          k_cnt      <= inc_sat(k_cnt);
          if (cnt == '0) begin
            state   <= STREAM;
            ready_q <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif

        STREAM: begin
          if (!pix_valid) begin
            row_err <= 1'b1;
            state   <= FLUSH;
            cnt     <= CNT_W'(FLUSH_LEN - 1);
            ready_q <= 1'b0;
          end else if (row_start && !row_end && (k_cnt != FIRST_K)) begin
            row_err <= 1'b1;
            state   <= FLUSH;
            cnt     <= CNT_W'(FLUSH_LEN - 1);
            ready_q <= 1'b0;
          end else if ((k_cnt == K_MAX) && !row_end) begin
            row_err <= 1'b1;
            state   <= FLUSH;
            cnt     <= CNT_W'(FLUSH_LEN - 1);
            ready_q <= 1'b0;
          end else begin
            acc_in     <= pix_in;
            tag_v[0]   <= is_full(k_cnt);
            tag_col[0] <= centre_of(k_cnt);
            k_cnt      <= inc_sat(k_cnt);
            if (row_end) begin
              ready_q <= 1'b0;
`ifdef SEQ_ZERO_PAD_EN
              state <= PAD_POST;
              cnt   <= CNT_W'(P - 1);
`else
              state <= FLUSH;
              cnt   <= CNT_W'(FLUSH_LEN - 1);
`endif
            end
          end
        end

`ifdef SEQ_ZERO_PAD_EN
        PAD_POST: begin
          tag_v[0]   <= is_full(k_cnt);
          tag_col[0] <= centre_of(k_cnt);
          k_cnt      <= inc_sat(k_cnt);
          if (cnt == '0) begin
            state <= FLUSH;
            cnt   <= CNT_W'(FLUSH_LEN - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif

        FLUSH: begin
          ready_q <= 1'b0;
          if (cnt == '0) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            busy    <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          ready_q <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
